// File: rtl/sw_input_ctrl_pkg.sv
// Shared register-map constants for the slide-switch Avalon-MM controller.
package sw_input_ctrl_pkg;

   typedef logic [1:0] reg_addr_t;

   localparam reg_addr_t ADDR_DATA = 2'd0;
   localparam reg_addr_t ADDR_MASK = 2'd1;
   localparam reg_addr_t ADDR_EDGE = 2'd2;
   localparam reg_addr_t ADDR_CTRL = 2'd3;

   localparam int CTRL_RISE = 0;
   localparam int CTRL_FALL = 1;

   localparam logic [1:0] CTRL_RESET = 2'b01;

endpackage

// File: rtl/sw_debounce_bit.sv
// One switch bit: 2-flop synchronizer followed by an optional stability filter
// (built only when SW_INPUT_CTRL_DEBOUNCE_EN is defined).
module sw_debounce_bit
`ifdef SW_INPUT_CTRL_DEBOUNCE_EN
#(
   parameter int DEBOUNCE_CYCLES = 50000
)
`endif
(
   input  logic clk,
   input  logic reset_n,
   input  logic pin,
   output logic filt
);

   logic sync1_r;
   logic sync2_r;

   // Metastability guard for the asynchronous pin.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_r <= 1'b0;
         sync2_r <= 1'b0;
      end else begin
         sync1_r <= pin;
         sync2_r <= sync1_r;
      end
   end

`ifdef SW_INPUT_CTRL_DEBOUNCE_EN
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

   logic [CNT_W-1:0] cnt_r;
   logic             filt_r;

   // Accept a new level only after it has differed for DEBOUNCE_CYCLES cycles.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_r  <= '0;
         filt_r <= 1'b0;
      end else if (sync2_r == filt_r) begin
         cnt_r <= '0;
      end else if (cnt_r == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
         filt_r <= sync2_r;
         cnt_r  <= '0;
      end else begin
         cnt_r <= cnt_r + CNT_W'(1);
      end
   end

   assign filt = filt_r;
`else
   assign filt = sync2_r;
`endif

endmodule

// File: rtl/sw_input_ctrl.sv
// Avalon-MM slide-switch controller: synchronized/filtered inputs, edge capture, irq.
// Define SW_INPUT_CTRL_DEBOUNCE_EN to build the per-bit debounce counters.
module sw_input_ctrl
   import sw_input_ctrl_pkg::*;
#(
   parameter int WIDTH           = 10,
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] in_port,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   output logic             irq
);

   if ((WIDTH < 1) || (WIDTH > 32) || (DEBOUNCE_CYCLES < 2)) begin : g_bad_cfg
      $error("sw_input_ctrl: WIDTH must be 1..32 and DEBOUNCE_CYCLES >= 2");
   end

   logic [WIDTH-1:0] filt_s;
   logic [WIDTH-1:0] filt_prev_r;
   logic [WIDTH-1:0] mask_r;
   logic [WIDTH-1:0] edge_r;
   logic [1:0]       ctrl_r;
   logic [WIDTH-1:0] set_s;
   logic [WIDTH-1:0] clr_s;
   logic [31:0]      rd_mux_s;
   logic             wr_s;
   logic             unused_wdata_s;

   assign wr_s           = chipselect & ~write_n;
   assign unused_wdata_s = ^writedata;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      sw_debounce_bit
`ifdef SW_INPUT_CTRL_DEBOUNCE_EN
         #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES))
`endif
         u_bit (
            .clk     (clk),
            .reset_n (reset_n),
            .pin     (in_port[i]),
            .filt    (filt_s[i])
         );
   end

   // Edge events from the filtered state and the W1C clear mask.
   always_comb begin
      set_s = ((filt_s & ~filt_prev_r) & {WIDTH{ctrl_r[CTRL_RISE]}})
            | ((~filt_s & filt_prev_r) & {WIDTH{ctrl_r[CTRL_FALL]}});
      if (wr_s && (address == ADDR_EDGE)) begin
         clr_s = writedata[WIDTH-1:0];
      end else begin
         clr_s = '0;
      end
   end

   // Register file and irq; a capture outranks a same-cycle W1C of that bit.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         filt_prev_r <= '0;
         mask_r      <= '0;
         edge_r      <= '0;
         ctrl_r      <= CTRL_RESET;
         irq         <= 1'b0;
      end else begin
         filt_prev_r <= filt_s;
         edge_r      <= set_s | (edge_r & ~clr_s);
         irq         <= |(edge_r & mask_r);
         if (wr_s && (address == ADDR_MASK)) begin
            mask_r <= writedata[WIDTH-1:0];
         end
         if (wr_s && (address == ADDR_CTRL)) begin
            ctrl_r <= writedata[1:0];
         end
      end
   end

   // Read mux; chipselect is deliberately ignored, as on the plain PIO.
   always_comb begin
      rd_mux_s = 32'h0000_0000;
      case (address)
         ADDR_DATA: rd_mux_s = 32'(filt_s);
         ADDR_MASK: rd_mux_s = 32'(mask_r);
         ADDR_EDGE: rd_mux_s = 32'(edge_r);
         ADDR_CTRL: rd_mux_s = 32'(ctrl_r);
         default:   rd_mux_s = 32'h0000_0000;
      endcase
   end

   // One-cycle read latency.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         readdata <= 32'h0000_0000;
      end else begin
         readdata <= rd_mux_s;
      end
   end

endmodule

// File: tb/tb_sw_input_ctrl.sv
// Self-checking bench for sw_input_ctrl: directed scenarios plus randomized traffic
// compared against a history-based reference model.
module tb_sw_input_ctrl;

   localparam int W = 10;
   localparam int D = 8;
`ifdef SW_INPUT_CTRL_DEBOUNCE_EN
   localparam int FLAT = 2 + D;
`else
   localparam int FLAT = 2;
`endif

   logic          clk = 1'b0;
   logic          reset_n;
   logic [W-1:0]  in_port;
   logic [1:0]    address;
   logic          chipselect;
   logic          write_n;
   logic [31:0]   writedata;
   logic [31:0]   readdata;
   logic          irq;

   int n_tests = 0;
   int n_fail  = 0;

   sw_input_ctrl #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .in_port    (in_port),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .irq        (irq)
   );

   always #5 clk = ~clk;

   // Reference model: pin samples since reset, filtered level derived from that history.
   logic [W-1:0] pins[$];
   logic [W-1:0] m_filt, m_prev, m_mask, m_edge;
   logic [1:0]   m_ctrl;
   logic         m_irq;
   logic [31:0]  m_rdata;

`ifdef SW_INPUT_CTRL_DEBOUNCE_EN
   // Synchronized level seen just before clock edge m (1-based since reset).
   function automatic logic [W-1:0] sync2_before(int m);
      if (m >= 3) return pins[m-3];
      return '0;
   endfunction

   // A bit flips once the synchronized level has opposed it for D consecutive edges.
   function automatic logic [W-1:0] next_filt(int n, logic [W-1:0] cur);
      logic [W-1:0] nf;
      logic [W-1:0] s;
      bit           stable;
      nf = cur;
      for (int b = 0; b < W; b++) begin
         stable = 1'b1;
         for (int k = 0; k < D; k++) begin
            s = sync2_before(n - k);
            if (s[b] == cur[b]) stable = 1'b0;
         end
         if (stable) nf[b] = ~cur[b];
      end
      return nf;
   endfunction
`else
   function automatic logic [W-1:0] next_filt(int n);
      if (n >= 2) return pins[n-2];
      return '0;
   endfunction
`endif

   always @(posedge clk or negedge reset_n) begin
      logic [W-1:0] set_v, clr_v, nf;
      logic [31:0]  rd_v;
      bit           wr_v;
      if (!reset_n) begin
         pins.delete();
         m_filt  = '0;
         m_prev  = '0;
         m_mask  = '0;
         m_edge  = '0;
         m_ctrl  = 2'b01;
         m_irq   = 1'b0;
         m_rdata = 32'h0;
      end else begin
         case (address)
            2'd0:    rd_v = {22'h0, m_filt};
            2'd1:    rd_v = {22'h0, m_mask};
            2'd2:    rd_v = {22'h0, m_edge};
            default: rd_v = {30'h0, m_ctrl};
         endcase
         wr_v  = chipselect && !write_n;
         set_v = 0;
         for (int b = 0; b < W; b++) begin
            if (m_filt[b] && !m_prev[b] && m_ctrl[0]) set_v[b] = 1'b1;
            if (!m_filt[b] && m_prev[b] && m_ctrl[1]) set_v[b] = 1'b1;
         end
         clr_v = (wr_v && address == 2'd2) ? writedata[W-1:0] : '0;
         m_irq = (m_edge & m_mask) != 0;
         m_edge = set_v | (m_edge & ~clr_v);
         if (wr_v && address == 2'd1) m_mask = writedata[W-1:0];
         if (wr_v && address == 2'd3) m_ctrl = writedata[1:0];
         pins.push_back(in_port);
`ifdef SW_INPUT_CTRL_DEBOUNCE_EN
         nf = next_filt(pins.size(), m_filt);
`else
         nf = next_filt(pins.size());
`endif
         m_prev  = m_filt;
         m_filt  = nf;
         m_rdata = rd_v;
      end
   end

   task automatic tick(int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wr(logic [1:0] a, logic [31:0] d);
      address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
      @(negedge clk);
      chipselect = 1'b0; write_n = 1'b1;
   endtask

   task automatic rd(logic [1:0] a);
      address = a;
      @(negedge clk);
   endtask

   task automatic test_reset();
      logic [31:0] exp;
      reset_n = 1'b0; in_port = '0; address = 2'd0;
      chipselect = 1'b0; write_n = 1'b1; writedata = 32'h0;
      tick(3);
      reset_n = 1'b1;
      for (int a = 0; a < 4; a++) begin
         rd(2'(a));
         exp = (a == 3) ? 32'h1 : 32'h0;
         n_tests++;
         if (readdata !== exp || readdata !== m_rdata) begin
            n_fail++;
            $display("FAIL reset_read[%0d]: got %h expected %h", a, readdata, exp);
         end
      end
      n_tests++;
      if (irq !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_irq: got %b expected 0", irq);
      end
   endtask

   task automatic test_capture();
      address = 2'd0; in_port = 10'h005;
      tick(FLAT + 1);
      n_tests++;
      if (readdata !== 32'h005 || readdata !== m_rdata) begin
         n_fail++;
         $display("FAIL capture_data: got %h expected %h", readdata, 32'h005);
      end
      rd(2'd2);
      n_tests++;
      if (readdata !== 32'h005 || readdata !== m_rdata) begin
         n_fail++;
         $display("FAIL capture_edge: got %h expected %h", readdata, 32'h005);
      end
      n_tests++;
      if (irq !== 1'b0) begin
         n_fail++;
         $display("FAIL capture_irq_masked: got %b expected 0", irq);
      end
   endtask

   task automatic test_irq();
      wr(2'd1, 32'h001);
      n_tests++;
      if (irq !== 1'b0) begin
         n_fail++;
         $display("FAIL irq_before_mask: got %b expected 0", irq);
      end
      tick(1);
      n_tests++;
      if (irq !== 1'b1 || irq !== m_irq) begin
         n_fail++;
         $display("FAIL irq_assert: got %b expected 1", irq);
      end
      wr(2'd2, 32'h001);
      n_tests++;
      if (irq !== 1'b1) begin
         n_fail++;
         $display("FAIL irq_hold_on_clear_edge: got %b expected 1", irq);
      end
      tick(1);
      n_tests++;
      if (irq !== 1'b0 || irq !== m_irq) begin
         n_fail++;
         $display("FAIL irq_deassert: got %b expected 0", irq);
      end
      rd(2'd2);
      n_tests++;
      if (readdata !== 32'h004 || readdata !== m_rdata) begin
         n_fail++;
         $display("FAIL w1c_edge: got %h expected %h", readdata, 32'h004);
      end
   endtask

   task automatic test_fall();
      wr(2'd2, 32'h3FF);
      wr(2'd3, 32'h2);
      in_port = 10'h001;
      tick(FLAT + 1);
      rd(2'd2);
      n_tests++;
      if (readdata !== 32'h004 || readdata !== m_rdata) begin
         n_fail++;
         $display("FAIL fall_capture: got %h expected %h", readdata, 32'h004);
      end
      in_port = 10'h009;
      tick(FLAT + 1);
      rd(2'd2);
      n_tests++;
      if (readdata !== 32'h004 || readdata !== m_rdata) begin
         n_fail++;
         $display("FAIL rise_ignored: got %h expected %h", readdata, 32'h004);
      end
      wr(2'd2, 32'h004);
      in_port = 10'h00D;
      tick(FLAT + 1);
      in_port = 10'h009;
      tick(FLAT);
      wr(2'd2, 32'h004);
      rd(2'd2);
      n_tests++;
      if (readdata !== 32'h004 || readdata !== m_rdata) begin
         n_fail++;
         $display("FAIL set_beats_w1c: got %h expected %h", readdata, 32'h004);
      end
   endtask

`ifdef SW_INPUT_CTRL_DEBOUNCE_EN
   task automatic test_debounce();
      wr(2'd3, 32'h1);
      in_port = 10'h000;
      tick(FLAT + 2);
      wr(2'd2, 32'h3FF);
      in_port = 10'h001;
      tick(5);
      in_port = 10'h000;
      tick(20);
      rd(2'd0);
      n_tests++;
      if (readdata !== 32'h0 || readdata !== m_rdata) begin
         n_fail++;
         $display("FAIL glitch_data: got %h expected 0", readdata);
      end
      rd(2'd2);
      n_tests++;
      if (readdata !== 32'h0 || readdata !== m_rdata) begin
         n_fail++;
         $display("FAIL glitch_edge: got %h expected 0", readdata);
      end
      address = 2'd0; in_port = 10'h001;
      tick(FLAT);
      n_tests++;
      if (readdata !== 32'h0) begin
         n_fail++;
         $display("FAIL debounce_early: got %h expected 0", readdata);
      end
      tick(1);
      n_tests++;
      if (readdata !== 32'h1 || readdata !== m_rdata) begin
         n_fail++;
         $display("FAIL debounce_accept: got %h expected 1", readdata);
      end
   endtask
`endif

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(0, FLAT) == 0) in_port = W'($urandom);
         address    = 2'($urandom_range(0, 3));
         chipselect = 1'($urandom_range(0, 1));
         write_n    = ($urandom_range(0, 2) != 0);
         writedata  = $urandom;
         @(negedge clk);
         n_tests++;
         if (readdata !== m_rdata) begin
            n_fail++;
            $display("FAIL random_read cycle %0d: got %h expected %h", c, readdata, m_rdata);
         end
         n_tests++;
         if (irq !== m_irq) begin
            n_fail++;
            $display("FAIL random_irq cycle %0d: got %b expected %b", c, irq, m_irq);
         end
      end
      chipselect = 1'b0; write_n = 1'b1;
   endtask

   task automatic test_reset_mid();
      in_port = 10'h000;
      tick(FLAT + 2);
      in_port = 10'h3FF;
      tick(4);
      reset_n = 1'b0;
      tick(2);
      reset_n = 1'b1;
      rd(2'd0);
      n_tests++;
      if (readdata !== 32'h0 || readdata !== m_rdata) begin
         n_fail++;
         $display("FAIL reset_mid_data: got %h expected 0", readdata);
      end
      tick(FLAT - 1);
      n_tests++;
      if (readdata !== 32'h0 || readdata !== m_rdata) begin
         n_fail++;
         $display("FAIL reset_mid_early: got %h expected 0", readdata);
      end
      tick(1);
      n_tests++;
      if (readdata !== 32'h3FF || readdata !== m_rdata) begin
         n_fail++;
         $display("FAIL reset_mid_latency: got %h expected %h", readdata, 32'h3FF);
      end
      rd(2'd2);
      n_tests++;
      if (readdata !== 32'h3FF || readdata !== m_rdata) begin
         n_fail++;
         $display("FAIL reset_mid_edge: got %h expected %h", readdata, 32'h3FF);
      end
      n_tests++;
      if (irq !== 1'b0 || irq !== m_irq) begin
         n_fail++;
         $display("FAIL reset_mid_irq: got %b expected 0", irq);
      end
   endtask

   initial begin
      test_reset();
      test_capture();
      test_irq();
      test_fall();
`ifdef SW_INPUT_CTRL_DEBOUNCE_EN
      test_debounce();
`endif
      test_random();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
